uart_rx_framed: RTL and testbench

//  Parametrised async serial receiver: configurable data width, parity mode, stop-bit count, oversampling.

---
 rtl/uart_rx_framed_if.sv | 27 ++
 rtl/uart_rx_framed.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_framed_if.sv
// Receive-side handshake bundle for uart_rx_framed: one held word plus its
// error flags, offered with valid/ready.
interface uart_rx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_parity_err;
    logic                 m_frame_err;

    modport master (
        output m_data,
        output m_valid,
        output m_parity_err,
        output m_frame_err,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_parity_err,
        input  m_frame_err,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_framed.sv
// Parametrised async serial receiver with 3-sample majority vote, parity/framing
// checks, break detection and a 1-deep valid/ready output holding register.
module uart_rx_framed #(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RxD,
    uart_rx_framed_if.master       m_if,
    output logic                   overrun,
    output logic                   break_det,
    output logic                   rx_busy
);

    localparam int SAMPLE_RATE = Baud * Oversampling;
    localparam int DIV = (ClkFrequency + SAMPLE_RATE / 2) / SAMPLE_RATE;
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(Oversampling);
    localparam int BW  = $clog2(DATA_BITS);

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_framed: clock too slow for Baud*Oversampling (DIV < 1)");
    end
    if (Oversampling < 8 || (Oversampling & (Oversampling - 1)) != 0) begin : g_os_check
        $error("uart_rx_framed: Oversampling must be a power of 2 and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_check
        $error("uart_rx_framed: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_par_check
        $error("uart_rx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_rx_framed: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [1:0]           sync_q, sync_d;
    logic [SW-1:0]        sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop_err_q, stop_err_d;
    logic                 commit_q, commit_d;
    logic [DATA_BITS-1:0] m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_parity_err_q, m_parity_err_d;
    logic                 m_frame_err_q, m_frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 break_det_q, break_det_d;
    logic                 rx_busy_q, rx_busy_d;

    logic rx_s;
    logic tick;
    logic decide;
    logic bit_end;
    logic bit_val;
    logic accept;
    logic frame_par_err;

    always_comb begin
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        sync_d         = {sync_q[0], RxD};
        sample_cnt_d   = sample_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        samp_d         = samp_q;
        shift_d        = shift_q;
        par_bit_d      = par_bit_q;
        stop_err_d     = stop_err_q;
        commit_d       = 1'b0;
        m_data_d       = m_data_q;
        m_valid_d      = m_valid_q;
        m_parity_err_d = m_parity_err_q;
        m_frame_err_d  = m_frame_err_q;
        overrun_d      = 1'b0;
        break_det_d    = 1'b0;

        rx_s    = sync_q[1];
        tick    = (tick_cnt_q == TW'(DIV - 1));
        decide  = tick && (sample_cnt_q == SW'(Oversampling / 2 + 1));
        bit_end = tick && (sample_cnt_q == SW'(Oversampling - 1));
        bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
        accept  = m_valid_q && m_if.m_ready;

        if (PARITY == 1) begin
            frame_par_err = ~(^{shift_q, par_bit_q});
        end else if (PARITY == 2) begin
            frame_par_err = ^{shift_q, par_bit_q};
        end else begin
            frame_par_err = 1'b0;
        end

        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

        // The first two vote samples are banked; the third is the live sample at the decision tick.
        if (tick && state_q != S_IDLE) begin
            if (sample_cnt_q == SW'(Oversampling / 2 - 1)) samp_d[0] = rx_s;
            if (sample_cnt_q == SW'(Oversampling / 2))     samp_d[1] = rx_s;
            sample_cnt_d = sample_cnt_q + SW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (tick && !rx_s) begin
                    state_d      = S_START;
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                    stop_err_d   = 1'b0;
                end
            end
            S_START: begin
                if (decide && bit_val) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    par_bit_d = bit_val;
                end
                if (bit_end) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                // Committing at the last stop-bit decision lets the next start edge be seen early.
                if (decide) begin
                    stop_err_d = stop_err_q | ~bit_val;
                    if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        state_d  = S_IDLE;
                        commit_d = 1'b1;
                    end
                end else if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            m_valid_d      = 1'b0;
            m_parity_err_d = 1'b0;
            m_frame_err_d  = 1'b0;
        end

        // A completed frame only replaces the held word if that word is gone or leaving now.
        if (commit_q) begin
            if (!m_valid_q || accept) begin
                m_data_d       = shift_q;
                m_valid_d      = 1'b1;
                m_parity_err_d = frame_par_err;
                m_frame_err_d  = stop_err_q;
            end else begin
                overrun_d = 1'b1;
            end
            break_det_d = (shift_q == '0) && stop_err_q;
        end

        rx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            tick_cnt_q     <= '0;
            sync_q         <= 2'b11;
            sample_cnt_q   <= '0;
            bit_cnt_q      <= '0;
            samp_q         <= 2'b11;
            shift_q        <= '0;
            par_bit_q      <= 1'b0;
            stop_err_q     <= 1'b0;
            commit_q       <= 1'b0;
            m_data_q       <= '0;
            m_valid_q      <= 1'b0;
            m_parity_err_q <= 1'b0;
            m_frame_err_q  <= 1'b0;
            overrun_q      <= 1'b0;
            break_det_q    <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            sync_q         <= sync_d;
            sample_cnt_q   <= sample_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            samp_q         <= samp_d;
            shift_q        <= shift_d;
            par_bit_q      <= par_bit_d;
            stop_err_q     <= stop_err_d;
            commit_q       <= commit_d;
            m_data_q       <= m_data_d;
            m_valid_q      <= m_valid_d;
            m_parity_err_q <= m_parity_err_d;
            m_frame_err_q  <= m_frame_err_d;
            overrun_q      <= overrun_d;
            break_det_q    <= break_det_d;
            rx_busy_q      <= rx_busy_d;
        end
    end

    assign m_if.m_data       = m_data_q;
    assign m_if.m_valid      = m_valid_q;
    assign m_if.m_parity_err = m_parity_err_q;
    assign m_if.m_frame_err  = m_frame_err_q;
    assign overrun           = overrun_q;
    assign break_det         = break_det_q;
    assign rx_busy           = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: an 8N1 receiver (A) and an 8E1 receiver (B)
// at 32 clk per bit, with hand-computed expectations.
module tb_uart_rx_framed;

    localparam int BitClk = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxdA = 1'b1;
    logic rxdB = 1'b1;
    logic overrunA, breakA, busyA;
    logic overrunB, breakB, busyB;

    int assertCount = 0;
    int failCount   = 0;

    int       validCntA, overrunCntA, breakCntA;
    logic [7:0] lastDataA;
    logic     lastPerrA, lastFerrA;
    int       validCntB, overrunCntB, breakCntB;
    logic [7:0] lastDataB;
    logic     lastPerrB, lastFerrB;

    uart_rx_framed_if #(.DATA_BITS(8)) busA ();
    uart_rx_framed_if #(.DATA_BITS(8)) busB ();

    uart_rx_framed #(
        .ClkFrequency(3200000), .Baud(100000), .Oversampling(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dutA (
        .clk(clk), .rst(rst), .RxD(rxdA), .m_if(busA),
        .overrun(overrunA), .break_det(breakA), .rx_busy(busyA)
    );

    uart_rx_framed #(
        .ClkFrequency(3200000), .Baud(100000), .Oversampling(16),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dutB (
        .clk(clk), .rst(rst), .RxD(rxdB), .m_if(busB),
        .overrun(overrunB), .break_det(breakB), .rx_busy(busyB)
    );

    always #5 clk = ~clk;

    // Watch both receivers on the falling edge and tally what each one produced.
    always @(negedge clk) begin
        if (busA.m_valid) begin
            validCntA++;
            lastDataA = busA.m_data;
            lastPerrA = busA.m_parity_err;
            lastFerrA = busA.m_frame_err;
        end
        if (overrunA) overrunCntA++;
        if (breakA)   breakCntA++;
        if (busB.m_valid) begin
            validCntB++;
            lastDataB = busB.m_data;
            lastPerrB = busB.m_parity_err;
            lastFerrB = busB.m_frame_err;
        end
        if (overrunB) overrunCntB++;
        if (breakB)   breakCntB++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tickClk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearTallies();
        validCntA = 0; overrunCntA = 0; breakCntA = 0;
        lastDataA = '0; lastPerrA = 1'b0; lastFerrA = 1'b0;
        validCntB = 0; overrunCntB = 0; breakCntB = 0;
        lastDataB = '0; lastPerrB = 1'b0; lastFerrB = 1'b0;
    endtask

    task automatic driveBit(input bit useB, input logic v, input int clks);
        if (useB) rxdB = v;
        else      rxdA = v;
        tickClk(clks);
    endtask

    // Full frame: start, 8 data LSB first, parity (B only), one stop bit, then two idle bits.
    task automatic applyStimulus(input bit useB, input logic [7:0] data, input logic parBit, input logic stopBit);
        driveBit(useB, 1'b0, BitClk);
        for (int i = 0; i < 8; i++) driveBit(useB, data[i], BitClk);
        if (useB) driveBit(useB, parBit, BitClk);
        driveBit(useB, stopBit, BitClk);
        driveBit(useB, 1'b1, 2 * BitClk);
    endtask

    initial begin
        int busyCleared;
        logic [7:0] partial;

        busA.m_ready = 1'b1;
        busB.m_ready = 1'b1;
        clearTallies();
        rst = 1'b1;
        tickClk(3);
        rst = 1'b0;
        tickClk(2);

        $display("[TB] reset state");
        checkOutput("rst_valid_a", {31'd0, busA.m_valid}, 32'd0);
        checkOutput("rst_data_a", {24'd0, busA.m_data}, 32'd0);
        checkOutput("rst_busy_a", {31'd0, busyA}, 32'd0);
        checkOutput("rst_flags_a", {29'd0, busA.m_parity_err, busA.m_frame_err, overrunA}, 32'd0);
        checkOutput("rst_break_a", {31'd0, breakA}, 32'd0);
        checkOutput("rst_valid_b", {31'd0, busB.m_valid}, 32'd0);

        $display("[TB] 8N1 0xA5");
        clearTallies();
        applyStimulus(1'b0, 8'hA5, 1'b0, 1'b1);
        checkOutput("t1_data", {24'd0, lastDataA}, 32'hA5);
        checkOutput("t1_valid_cycles", validCntA, 32'd1);
        checkOutput("t1_perr", {31'd0, lastPerrA}, 32'd0);
        checkOutput("t1_ferr", {31'd0, lastFerrA}, 32'd0);
        checkOutput("t1_overrun", overrunCntA, 32'd0);
        checkOutput("t1_busy_idle", {31'd0, busyA}, 32'd0);

        $display("[TB] even parity 0x07");
        clearTallies();
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b1);
        checkOutput("t2_data_bad", {24'd0, lastDataB}, 32'h07);
        checkOutput("t2_perr_bad", {31'd0, lastPerrB}, 32'd1);
        checkOutput("t2_ferr_bad", {31'd0, lastFerrB}, 32'd0);
        clearTallies();
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b1);
        checkOutput("t2_data_good", {24'd0, lastDataB}, 32'h07);
        checkOutput("t2_perr_good", {31'd0, lastPerrB}, 32'd0);
        checkOutput("t2_valid_cycles", validCntB, 32'd1);

        $display("[TB] framing error and break");
        clearTallies();
        applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0);
        checkOutput("t3_data", {24'd0, lastDataA}, 32'h3C);
        checkOutput("t3_ferr", {31'd0, lastFerrA}, 32'd1);
        checkOutput("t3_no_break", breakCntA, 32'd0);
        clearTallies();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t3_break_data", {24'd0, lastDataA}, 32'h00);
        checkOutput("t3_break_ferr", {31'd0, lastFerrA}, 32'd1);
        checkOutput("t3_break_pulse", breakCntA, 32'd1);

        $display("[TB] start-bit glitch");
        clearTallies();
        driveBit(1'b0, 1'b0, 6);
        checkOutput("t4_busy_on_glitch", {31'd0, busyA}, 32'd1);
        rxdA = 1'b1;
        busyCleared = 0;
        for (int i = 0; i < BitClk && busyCleared == 0; i++) begin
            tickClk(1);
            if (!busyA) busyCleared = 1;
        end
        checkOutput("t4_busy_cleared", busyCleared, 32'd1);
        tickClk(2 * BitClk);
        checkOutput("t4_no_valid", validCntA, 32'd0);

        $display("[TB] overrun");
        clearTallies();
        busA.m_ready = 1'b0;
        applyStimulus(1'b0, 8'h11, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h22, 1'b0, 1'b1);
        checkOutput("t5_held_data", {24'd0, busA.m_data}, 32'h11);
        checkOutput("t5_held_valid", {31'd0, busA.m_valid}, 32'd1);
        checkOutput("t5_overrun_pulses", overrunCntA, 32'd1);
        busA.m_ready = 1'b1;
        tickClk(1);
        checkOutput("t5_valid_drop", {31'd0, busA.m_valid}, 32'd0);

        $display("[TB] reset mid-frame");
        busA.m_ready = 1'b0;
        applyStimulus(1'b0, 8'h77, 1'b0, 1'b1);
        checkOutput("t6_pre_valid", {31'd0, busA.m_valid}, 32'd1);
        partial = 8'h3C;
        driveBit(1'b0, 1'b0, BitClk);
        for (int i = 0; i < 3; i++) driveBit(1'b0, partial[i], BitClk);
        driveBit(1'b0, partial[3], BitClk / 2);
        checkOutput("t6_busy_before_rst", {31'd0, busyA}, 32'd1);
        rst = 1'b1;
        rxdA = 1'b1;
        tickClk(1);
        rst = 1'b0;
        checkOutput("t6_busy_after_rst", {31'd0, busyA}, 32'd0);
        checkOutput("t6_valid_after_rst", {31'd0, busA.m_valid}, 32'd0);
        checkOutput("t6_data_after_rst", {24'd0, busA.m_data}, 32'd0);
        tickClk(2 * BitClk);
        busA.m_ready = 1'b1;
        clearTallies();
        applyStimulus(1'b0, 8'h5A, 1'b0, 1'b1);
        checkOutput("t6_data_5a", {24'd0, lastDataA}, 32'h5A);
        checkOutput("t6_valid_cycles", validCntA, 32'd1);
        checkOutput("t6_ferr", {31'd0, lastFerrA}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
